// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX path.
// This file holds the framing FSM state encoding, the serial line levels
// and the default data width. It also has a small helper that sizes the
// bit counter.
package uart_tx_pkg;

    // Default number of data bits per frame.
    localparam int DEF_DATA_WIDTH = 8;

    // Serial line levels for the idle line, the start bit and the stop bit.
    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Framing FSM states. The 3-bit encoding is visible on the debug port.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Width of a counter that must hold the values 0 .. w-1.
    // The result is never narrower than one bit, so a 1-bit frame
    // still gets a legal vector.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage : uart_tx_pkg

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter for the UART TX framing controller.
//
// On a load, the word is captured and the counter cleared.
// Each shift_en pulse does two things: it moves the current bit 0 onto
// the line, and it shifts the register right by one.
//
// The first shift after a load happens in START. It hands data bit 0 to
// the line, and the counter stays at 0. After that, every shift also
// increments the counter. As a result, while the FSM is in DATA, the
// counter equals the index of the bit currently on the line.
// ser_done is high while that index is DATA_WIDTH-1.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int               CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  primed;

    // Shift register, bit counter and first-shift flag.
    // Reset or load clears all of them.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg   <= '0;
            bit_cnt <= '0;
            primed  <= 1'b0;
        end else if (load) begin
            shreg   <= load_data;
            bit_cnt <= '0;
            primed  <= 1'b0;
        end else if (shift_en) begin
            shreg  <= shreg >> 1;
            primed <= 1'b1;
            if (primed) begin
                bit_cnt <= bit_cnt + CNT_ONE;
            end
        end
    end

    // The next bit to put on the line is always the register LSB.
    assign ser_bit = shreg[0];

    // The last data bit is on the line: the FSM leaves DATA on this edge.
    assign ser_done = primed && (bit_cnt == LAST_IDX);

endmodule : uart_tx_serializer

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX framing controller.
//
// Serialises one parallel word per frame at one bit per CLK cycle, in this
// order: start bit, data bits LSB first, optional parity bit, stop bit.
// The parity bit comes from the upstream parity calculator (par_bit). It is
// sampled on the edge that enters PARITY.
//
// Handshake: DATA_VALID is the request, and busy low is the ready. A word is
// accepted on a rising edge where DATA_VALID=1 while busy=0; that is exactly
// when the FSM is in IDLE. A request that arrives while busy=1 is dropped,
// not queued. The requester must hold DATA_VALID until it sees busy rise.
//
// TX_OUT and busy are registers that are updated on the same edge as the
// state. Each one holds the value that belongs to the state just entered.
// No input reaches an output without passing through a register.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic [2:0]            dbg_state
);

    tx_state_e state;
    logic      par_en_q;
    logic      load;
    logic      shift_en;
    logic      ser_bit;
    logic      ser_done;

    // A word is accepted only from IDLE. This drives the serializer load.
    assign load = (state == IDLE) && DATA_VALID;

    // Shift in START to present data bit 0. Then keep shifting in DATA
    // until the last bit is on the line.
    assign shift_en = (state == START) || ((state == DATA) && !ser_done);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .shift_en  (shift_en),
        .load_data (P_DATA),
        .ser_bit   (ser_bit),
        .ser_done  (ser_done)
    );

    // Framing FSM with registered line and busy outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            TX_OUT   <= IDLE_LVL;
            busy     <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT <= IDLE_LVL;
                    busy   <= 1'b0;
                    if (DATA_VALID) begin
                        par_en_q <= PAR_EN;
                        state    <= START;
                        TX_OUT   <= START_LVL;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    state  <= DATA;
                    TX_OUT <= ser_bit;
                end
                DATA: begin
                    if (ser_done) begin
                        if (par_en_q) begin
                            state  <= PARITY;
                            TX_OUT <= par_bit;
                        end else begin
                            state  <= STOP;
                            TX_OUT <= STOP_LVL;
                        end
                    end else begin
                        TX_OUT <= ser_bit;
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= STOP_LVL;
                end
                STOP: begin
                    state  <= IDLE;
                    TX_OUT <= IDLE_LVL;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= IDLE_LVL;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

    // busy is a registered copy of "not in IDLE".
    a_busy_matches_state : assert property (
        @(posedge CLK) disable iff (!RST) busy == (state != IDLE)
    );

    // The line only idles high when no frame is in progress.
    a_idle_line_high : assert property (
        @(posedge CLK) disable iff (!RST) !busy |-> TX_OUT
    );

endmodule : uart_tx_frame_ctrl
